// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin arbiter for one shared resource among N requesters.
// An owner keeps the grant while it holds its request, up to MAX_HOLD cycles;
// on expiry the grant is revoked and timeout pulses for one cycle. The most
// recent owner always becomes lowest priority at the next arbitration.
//
// Ports:
//   clock   - single clock, rising edge
//   reset   - asynchronous, active-high reset
//   req     - [N-1:0] level-sensitive request vector
//   gnt     - [N-1:0] registered one-hot (or zero) grant vector
//   gnt_id  - index of current owner; holds last owner while idle
//   busy    - high while any grant is active
//   timeout - one-cycle pulse after a forced revocation
module rr_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_id,
  output logic                 busy,
  output logic                 timeout
);

  localparam int IW = $clog2(N);
  localparam int HW = $clog2(MAX_HOLD + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state;
  logic [IW-1:0]   ptr;
  logic [HW-1:0]   hold_cnt;

  logic [2*N-1:0]  req_dbl;
  logic [N-1:0]    rot;
  logic            sel_found;
  logic [IW-1:0]   sel_idx;
  logic [IW:0]     sum;
  logic            owner_req;
  logic [IW-1:0]   ptr_next;

  // Rotate the request vector so that bit 0 is the requester at ptr; the
  // first set bit of the rotated vector is then the winner, offset by ptr.
  always_comb begin
    req_dbl   = {req, req} >> ptr;
    rot       = req_dbl[N-1:0];
    sel_found = 1'b0;
    sel_idx   = '0;
    sum       = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!sel_found && rot[i]) begin
        sel_found = 1'b1;
        sum       = {1'b0, ptr} + (IW+1)'(i);
        if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
        sel_idx   = sum[IW-1:0];
      end
    end
  end

  // gnt is one-hot while granting, so this tests req of the owner only.
  assign owner_req = |(req & gnt);
  assign ptr_next  = (gnt_id == IW'(N - 1)) ? '0 : gnt_id + 1'b1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      gnt      <= '0;
      gnt_id   <= '0;
      busy     <= 1'b0;
      timeout  <= 1'b0;
      ptr      <= '0;
      hold_cnt <= '0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (sel_found) begin
            gnt      <= N'(1) << sel_idx;
            gnt_id   <= sel_idx;
            busy     <= 1'b1;
            hold_cnt <= '0;
            state    <= GRANT;
          end
        end
        GRANT: begin
          if (!owner_req) begin
            gnt   <= '0;
            busy  <= 1'b0;
            ptr   <= ptr_next;
            state <= IDLE;
          end else if (hold_cnt == HW'(MAX_HOLD - 1)) begin
            gnt     <= '0;
            busy    <= 1'b0;
            ptr     <= ptr_next;
            timeout <= 1'b1;
            state   <= IDLE;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arbiter.sv
// Directed bench for rr_arbiter: N=4/MAX_HOLD=8 main instance plus a
// MAX_HOLD=1 instance for the single-cycle tenure corner.
module tb_rr_arbiter;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] req   = 4'b1111;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       busy;
  logic       timeout;

  logic [3:0] req1 = 4'b0000;
  logic [3:0] gnt1;
  logic [1:0] gnt_id1;
  logic       busy1;
  logic       timeout1;

  int errors = 0;
  int checks = 0;

  rr_arbiter #(.N(4), .MAX_HOLD(8)) dut (
    .clock(clock), .reset(reset), .req(req), .gnt(gnt),
    .gnt_id(gnt_id), .busy(busy), .timeout(timeout)
  );

  rr_arbiter #(.N(4), .MAX_HOLD(1)) dut1 (
    .clock(clock), .reset(reset), .req(req1), .gnt(gnt1),
    .gnt_id(gnt_id1), .busy(busy1), .timeout(timeout1)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic chk_main(input string tag, input logic [3:0] g, input logic b, input logic t);
    chk({tag, "_gnt"}, 32'(gnt), 32'(g));
    chk({tag, "_busy"}, 32'(busy), 32'(b));
    chk({tag, "_timeout"}, 32'(timeout), 32'(t));
  endtask

  initial begin
    logic [3:0] oh;
    logic [3:0] oh_next;

    // Reset held with all requests high, edge at t=5 occurs during reset.
    #8;
    chk_main("reset", 4'b0000, 1'b0, 1'b0);
    chk("reset_gnt_id", 32'(gnt_id), 32'd0);
    chk("reset_gnt1", 32'(gnt1), 32'd0);
    reset = 1'b0;
    step(1);
    chk_main("post_reset", 4'b0001, 1'b1, 1'b0);
    chk("post_reset_id", 32'(gnt_id), 32'd0);

    // Release owner 0 -> ptr=1.
    req = 4'b0000;
    step(1);
    chk_main("release0", 4'b0000, 1'b0, 1'b0);

    // Single requester 1, held for 3 grant cycles.
    req = 4'b0010;
    step(1);
    chk_main("single1", 4'b0010, 1'b1, 1'b0);
    chk("single1_id", 32'(gnt_id), 32'd1);
    step(2);
    chk_main("single1_hold", 4'b0010, 1'b1, 1'b0);
    req = 4'b0000;
    step(1);
    chk_main("single1_rel", 4'b0000, 1'b0, 1'b0);
    chk("single1_rel_id", 32'(gnt_id), 32'd1);

    // ptr=2: scan 2,3,0 -> requester 0 wins over 1.
    req = 4'b0011;
    step(1);
    chk_main("wrap_scan", 4'b0001, 1'b1, 1'b0);
    chk("wrap_scan_id", 32'(gnt_id), 32'd0);

    // Rotation: each owner releases after 2 grant cycles, then reasserts.
    req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      oh      = 4'b0001 << k;
      oh_next = 4'b0001 << ((k + 1) % 4);
      step(1);
      chk("rot_hold", 32'(gnt), 32'(oh));
      req = 4'b1111 & ~oh;
      step(1);
      chk_main("rot_dead", 4'b0000, 1'b0, 1'b0);
      req = 4'b1111;
      step(1);
      chk_main("rot_next", oh_next, 1'b1, 1'b0);
      chk("rot_next_id", 32'(gnt_id), 32'((k + 1) % 4));
    end

    // Lone requester 2 held: exactly 8 grant cycles, timeout, regrant.
    req = 4'b0000;
    step(1);
    chk_main("pre_to_rel", 4'b0000, 1'b0, 1'b0);
    req = 4'b0100;
    step(1);
    chk_main("to_c1", 4'b0100, 1'b1, 1'b0);
    for (int i = 2; i <= 8; i++) begin
      step(1);
      chk_main("to_hold", 4'b0100, 1'b1, 1'b0);
    end
    step(1);
    chk_main("to_pulse", 4'b0000, 1'b0, 1'b1);
    step(1);
    chk_main("to_regrant", 4'b0100, 1'b1, 1'b0);

    // Contention 0 and 2: owner 2 times out, then 0 for 8, then 2 again.
    req = 4'b0101;
    step(7);
    chk_main("ct_2_end", 4'b0100, 1'b1, 1'b0);
    step(1);
    chk_main("ct_to_a", 4'b0000, 1'b0, 1'b1);
    step(1);
    chk_main("ct_g0", 4'b0001, 1'b1, 1'b0);
    step(7);
    chk_main("ct_g0_end", 4'b0001, 1'b1, 1'b0);
    step(1);
    chk_main("ct_to_b", 4'b0000, 1'b0, 1'b1);
    step(1);
    chk_main("ct_g2", 4'b0100, 1'b1, 1'b0);
    chk("ct_g2_id", 32'(gnt_id), 32'd2);

    // Hand over to requester 3, then reset asynchronously mid-grant.
    req = 4'b1000;
    step(1);
    chk_main("pre_ar_rel", 4'b0000, 1'b0, 1'b0);
    step(1);
    chk_main("pre_ar_g3", 4'b1000, 1'b1, 1'b0);
    #3;
    reset = 1'b1;
    #1;
    chk_main("async_rst", 4'b0000, 1'b0, 1'b0);
    chk("async_rst_id", 32'(gnt_id), 32'd0);
    req   = 4'b1111;
    #1;
    reset = 1'b0;
    step(1);
    chk_main("after_ar", 4'b0001, 1'b1, 1'b0);

    // MAX_HOLD=1 instance: one-cycle grants, timeout after each.
    req1 = 4'b0010;
    step(1);
    chk("mh1_g", 32'(gnt1), 32'h2);
    chk("mh1_g_to", 32'(timeout1), 32'd0);
    step(1);
    chk("mh1_rev", 32'(gnt1), 32'h0);
    chk("mh1_rev_to", 32'(timeout1), 32'd1);
    step(1);
    chk("mh1_regrant", 32'(gnt1), 32'h2);
    chk("mh1_regrant_to", 32'(timeout1), 32'd0);
    // Release coinciding with tenure expiry is a normal release.
    req1 = 4'b0000;
    step(1);
    chk("mh1_simul_g", 32'(gnt1), 32'h0);
    chk("mh1_simul_to", 32'(timeout1), 32'd0);
    chk("mh1_simul_busy", 32'(busy1), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=no_finish expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
